fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port (`we`, `data_in`, `full`) between four producers. It grants one producer at a time for a bounded burst and gates writes on `full`, so no producer can overflow the FIFO. It returns a per-producer write acknowledge. It sits directly in front of the FIFO and drives its write side; the FIFO read side is untouched.

## Interface
- `DW`, 8, data width of each producer word and of the FIFO.
- `BURST`, 4, maximum consecutive writes per grant (range 1–16).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  4  per-producer request; held high while `req_data` slice is valid.
- `req_data`  in  4*DW  producer words; producer i at bits [i*DW +: DW].
- `ack`  out  4  one-hot; `ack[i]`=1 means producer i's word is written at this rising edge.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_we`  out  1  FIFO write enable.
- `fifo_din`  out  DW  FIFO write data.
- `owner`  out  2  index of the currently granted producer.
- `busy`  out  1  high in state OWN.

## Operation
- FSM states:
  - IDLE: no grant.
  - OWN: grant held by `owner`.
- Registers: `state`, `owner`, round-robin pointer `ptr` (2 bits), `bcnt` (burst counter, 0..BURST-1).
- IDLE → OWN when any `req` bit is high.
  - `owner` <= first i with `req[i]`=1, scanning `ptr`, `ptr`+1, ... mod 4.
  - `bcnt` <= 0.
  - No write happens in the IDLE cycle.
- Write condition in OWN: `wr` = `rst` & `req[owner]` & !`fifo_full` (combinational).
- Outputs driven from `wr`:
  - `fifo_we` = `wr`.
  - `ack` = `wr` ? (1<<`owner`) : 0.
  - `fifo_din` = `wr` ? `req_data[owner]` : 0.
- OWN behaviour per cycle:
  - `wr` & `bcnt`==BURST-1 → IDLE, `ptr` <= `owner`+1.
  - `wr` & `bcnt`<BURST-1 → stay OWN, `bcnt`++.
  - !`req[owner]` → IDLE, `ptr` <= `owner`+1. Grant is released without a write.
  - `req[owner]` & `fifo_full` → stay OWN, `bcnt` held. Back-pressure stall; the grant is not revoked.
- Producers must hold `req` and data stable until `ack`. Dropping `req` without `ack` withdraws the word; nothing is written.
- Requests from non-owners are ignored until the FSM returns to IDLE.
- `ptr` wraps 3 → 0.
- Reset (`rst`=0 at a rising edge): `state`=IDLE, `owner`=0, `ptr`=0, `bcnt`=0.
  - While `rst` is low, `fifo_we`, `ack`, and `fifo_din` are forced to 0 combinationally, even in the cycle before the reset edge.
  - A burst interrupted by reset is abandoned. After reset release, arbitration restarts from producer 0.

## Timing
- Grant latency: `req` high at edge k in IDLE → OWN from edge k. The first `fifo_we`/`ack` is visible in the following cycle and the write occurs at edge k+1.
- Throughput with a single continuous requester: BURST writes per BURST+1 cycles (one IDLE gap between grants).
- `busy` and `owner` are registered. `fifo_we`, `ack`, and `fifo_din` are combinational from registers, `req`, `req_data`, `fifo_full`, and `rst`.
- `fifo_full` asserted in a cycle blocks the write at that edge (same-cycle response).
- Reset output values: `fifo_we`=0, `ack`=0, `fifo_din`=0, `owner`=0, `busy`=0.

## Test plan
- Reset: hold `rst`=0 for 2 clocks with `req`=4'hF → `fifo_we`=0, `ack`=0, `busy`=0 throughout; after release, the first grant goes to `owner`=0.
- Single producer, BURST=4: `req[2]` held, 6 words 0x10..0x15 → writes of 0x10–0x13 on 4 consecutive edges, then 1 idle cycle, then 0x14, 0x15 on consecutive edges. `ack[2]` coincides with each write.
- Fairness: `req`=4'hF held continuously, BURST=4 → owner sequence 0,1,2,3,0, each with 4 writes and a 1-cycle gap between owners.
- Full stall: mid-burst for producer 1, force `fifo_full`=1 for 3 cycles → `fifo_we`=0 and `ack`=0 for those 3 cycles; `owner` stays 1 and `bcnt` is unchanged; the burst resumes and totals exactly 4 writes.
- Early release: producer 3 drops `req` after 2 acks → IDLE next edge, `ptr`=0, a pending `req[0]` is granted next, and no extra write occurs.
- Reset mid-burst: assert `rst`=0 after 2 writes of producer 1 → `fifo_we` is 0 in that same cycle; after release, `req`=4'b0010 is granted to producer 1 again from `bcnt`=0, giving a full 4-write burst.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among four producers in bounded bursts.
// One IDLE cycle per grant, then one write per cycle; fifo_full stalls the owner without revoking the grant.
module fifo_wr_arbiter #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [4*DW-1:0]   req_data,
    output logic [3:0]        ack,
    input  logic              fifo_full,
    output logic              fifo_we,
    output logic [DW-1:0]     fifo_din,
    output logic [1:0]        owner,
    output logic              busy
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] BCNT_LAST = 4'(BURST - 1);

    state_t      r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_ptr;
    logic [3:0]  r_bcnt;
    logic        r_busy;

    logic        w_wr;
    logic [1:0]  w_pick;
    logic [1:0]  w_idx;

    // Scan downward so the last hit is the one closest to r_ptr.
    always_comb begin
        w_idx  = r_ptr;
        w_pick = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_ptr + 2'(i);
            if (req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    assign w_wr     = rst && (r_state == OWN) && req[r_owner] && !fifo_full;
    assign fifo_we  = w_wr;
    assign ack      = w_wr ? (4'b0001 << r_owner) : 4'b0000;
    assign fifo_din = w_wr ? req_data[r_owner*DW +: DW] : '0;
    assign owner    = r_owner;
    assign busy     = r_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_bcnt  <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state <= OWN;
                        r_busy  <= 1'b1;
                        r_owner <= w_pick;
                        r_bcnt  <= 4'd0;
                    end
                end
                OWN: begin
                    if (!req[r_owner]) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_owner + 2'd1;
                    end else if (!fifo_full) begin
                        if (r_bcnt == BCNT_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ptr   <= r_owner + 2'd1;
                        end else begin
                            r_bcnt <= r_bcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [4*DW-1:0] req_data;
    logic            fifo_full;
    logic [3:0]      ack;
    logic            fifo_we;
    logic [DW-1:0]   fifo_din;
    logic [1:0]      owner;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DW(DW), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .owner     (owner),
        .busy      (busy)
    );

    // Leaves the bench at a negedge with rst released and the DUT in IDLE.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = 4'h0; fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'hF; fifo_full = 1'b0;
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_chk++;
            if ({fifo_we, ack, fifo_din, busy, owner} !== {1'b0, 4'h0, 8'h00, 1'b0, 2'd0})
                $display("FAIL reset_hold c%0d: we=%0b ack=%h din=%h busy=%0b owner=%0d, want all 0",
                         c, fifo_we, ack, fifo_din, busy, owner);
            else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        n_chk++;
        if ({busy, owner, fifo_we, ack, fifo_din} !== {1'b1, 2'd0, 1'b1, 4'b0001, 8'hD0})
            $display("FAIL reset_first_grant: busy=%0b owner=%0d we=%0b ack=%h din=%h, want 1 0 1 1 d0",
                     busy, owner, fifo_we, ack, fifo_din);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] we_pat = 8'b11011110;
        int idx = 0;
        logic e;
        logic [3:0] ea;
        logic [7:0] ed;
        do_reset();
        req_data = '0;
        for (int c = 0; c < 8; c++) begin
            req = 4'b0100;
            req_data[2*DW +: DW] = 8'(8'h10 + idx);
            #1;
            e  = we_pat[c];
            ea = e ? 4'b0100 : 4'b0000;
            ed = e ? 8'(8'h10 + idx) : 8'h00;
            n_chk++;
            if ({fifo_we, ack, fifo_din} !== {e, ea, ed})
                $display("FAIL single c%0d: we=%0b ack=%h din=%h, want we=%0b ack=%h din=%h",
                         c, fifo_we, ack, fifo_din, e, ea, ed);
            else n_pass++;
            if (e) idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_fairness();
        int ph, o;
        logic e;
        logic [3:0] ea;
        logic [7:0] ed;
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int c = 0; c < 25; c++) begin
            req = 4'hF;
            #1;
            ph = c % 5;
            o  = (c / 5) % 4;
            e  = (ph != 0);
            ea = e ? (4'b0001 << o) : 4'b0000;
            ed = e ? 8'(8'hA0 + o) : 8'h00;
            n_chk++;
            if ({fifo_we, ack, fifo_din, busy} !== {e, ea, ed, e})
                $display("FAIL fair c%0d: we=%0b ack=%h din=%h busy=%0b, want %0b %h %h %0b",
                         c, fifo_we, ack, fifo_din, busy, e, ea, ed, e);
            else n_pass++;
            if (e) begin
                n_chk++;
                if (owner !== 2'(o))
                    $display("FAIL fair_owner c%0d: owner=%0d want %0d", c, owner, o);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_stall();
        logic [8:0] we_pat   = 9'b011000110;
        logic [8:0] full_pat = 9'b000111000;
        int idx = 0;
        int wcnt = 0;
        logic e;
        do_reset();
        req_data = '0;
        for (int c = 0; c < 9; c++) begin
            req = 4'b0010;
            fifo_full = full_pat[c];
            req_data[1*DW +: DW] = 8'(8'h20 + idx);
            #1;
            e = we_pat[c];
            n_chk++;
            if ({fifo_we, ack, fifo_din} !== {e, (e ? 4'b0010 : 4'b0000), (e ? 8'(8'h20 + idx) : 8'h00)})
                $display("FAIL stall c%0d: we=%0b ack=%h din=%h, want we=%0b", c, fifo_we, ack, fifo_din, e);
            else n_pass++;
            if (c >= 1 && c <= 7) begin
                n_chk++;
                if ({busy, owner} !== {1'b1, 2'd1})
                    $display("FAIL stall_owner c%0d: busy=%0b owner=%0d, want 1 1", c, busy, owner);
                else n_pass++;
            end
            if (fifo_we === 1'b1) wcnt++;
            if (e) idx++;
            @(negedge clk);
        end
        fifo_full = 1'b0;
        n_chk++;
        if (wcnt != 4)
            $display("FAIL stall_total: writes=%0d want 4", wcnt);
        else n_pass++;
    endtask

    task automatic test_early_release();
        logic [3:0] req_t  [6] = '{4'b1000, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001};
        logic [3:0] ack_t  [6] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
        logic       busy_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] own_t  [6] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        logic [7:0] ed;
        do_reset();
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int c = 0; c < 6; c++) begin
            req = req_t[c];
            #1;
            ed = (ack_t[c] == 4'b1000) ? 8'h33 : (ack_t[c] == 4'b0001) ? 8'h30 : 8'h00;
            n_chk++;
            if ({fifo_we, ack, fifo_din, busy, owner} !== {|ack_t[c], ack_t[c], ed, busy_t[c], own_t[c]})
                $display("FAIL early c%0d: we=%0b ack=%h din=%h busy=%0b owner=%0d, want %0b %h %h %0b %0d",
                         c, fifo_we, ack, fifo_din, busy, owner, |ack_t[c], ack_t[c], ed, busy_t[c], own_t[c]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] we_pat  = 10'b0111100110;
        logic [9:0] rst_pat = 10'b1111110111;
        logic e;
        do_reset();
        req_data = {8'h44, 8'h00, 8'h55, 8'h00};
        for (int c = 0; c < 10; c++) begin
            req = 4'b0010;
            rst = rst_pat[c];
            #1;
            e = we_pat[c];
            n_chk++;
            if ({fifo_we, ack, fifo_din} !== {e, (e ? 4'b0010 : 4'b0000), (e ? 8'h55 : 8'h00)})
                $display("FAIL rstmid c%0d: we=%0b ack=%h din=%h, want we=%0b", c, fifo_we, ack, fifo_din, e);
            else n_pass++;
            if (c == 4) begin
                n_chk++;
                if ({busy, owner} !== {1'b0, 2'd0})
                    $display("FAIL rstmid_after: busy=%0b owner=%0d, want 0 0", busy, owner);
                else n_pass++;
            end
            if (c == 5 || c == 9) begin
                n_chk++;
                if ({busy, owner} !== {(c == 5), 2'd1})
                    $display("FAIL rstmid_grant c%0d: busy=%0b owner=%0d, want %0b 1", c, busy, owner, c == 5);
                else n_pass++;
            end
            @(negedge clk);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
